// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: default widths, reorder FSM states and bit reversal.
package fft_pkg;

  localparam int DW_DEF     = 24;
  localparam int N_LOG2_DEF = 10;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Reverses the low w bits of v; bits at or above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_ram.sv
// Simple dual-port RAM for the reorder buffer: synchronous write, registered read with hold.
module fft_bitrev_ram #(
  parameter int AW = 11,
  parameter int W  = 48
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The read register doubles as the output sample register, so it must reset and hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_buf.sv
// Ping-pong reorder buffer: captures bit-reversed FFT frames and streams them in natural order.
module fft_bitrev_buf
  import fft_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DW-1:0]     x_re_i,
  input  logic [DW-1:0]     x_im_i,
  output logic              valid_o,
  output logic [N_LOG2-1:0] ctr_o,
  output logic              last_o,
  output logic [DW-1:0]     z_re_o,
  output logic [DW-1:0]     z_im_o,
  output logic              overrun_o
);

  localparam logic [N_LOG2-1:0] CTR_MAX = {N_LOG2{1'b1}};

  logic [N_LOG2-1:0] wr_ctr_q, wr_ctr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_done;
  logic [N_LOG2-1:0] wr_rev;

  rd_state_e         state_q, state_d;
  logic [N_LOG2-1:0] rd_ctr_q, rd_ctr_d;
  logic              rd_bank_q, rd_bank_d;
  logic              overrun_q, overrun_d;
  logic              rd_issue;

  logic              valid_q;
  logic [N_LOG2-1:0] ctr_q;
  logic              last_q;
  logic [2*DW-1:0]   rdata;

  assign frame_done = frame_done_q;

  always_comb begin
    wr_ctr_d     = wr_ctr_q;
    wr_bank_d    = wr_bank_q;
    frame_done_d = 1'b0;
    wr_rev       = N_LOG2'(bitrev(32'(wr_ctr_q), N_LOG2));
    if (valid_i) begin
      wr_ctr_d = wr_ctr_q + N_LOG2'(1);
      if (wr_ctr_q == CTR_MAX) begin
        wr_bank_d    = ~wr_bank_q;
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ctr_q     <= '0;
      wr_bank_q    <= 1'b0;
      frame_done_q <= 1'b0;
      state_q      <= RD_IDLE;
      rd_ctr_q     <= '0;
      rd_bank_q    <= 1'b0;
      overrun_q    <= 1'b0;
      valid_q      <= 1'b0;
      ctr_q        <= '0;
      last_q       <= 1'b0;
    end else begin
      wr_ctr_q     <= wr_ctr_d;
      wr_bank_q    <= wr_bank_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      rd_ctr_q     <= rd_ctr_d;
      rd_bank_q    <= rd_bank_d;
      overrun_q    <= overrun_d;
      valid_q      <= rd_issue;
      ctr_q        <= rd_ctr_q;
      last_q       <= rd_issue && (rd_ctr_q == CTR_MAX);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: if (frame_done) state_d = RD_READ;
      RD_READ: if (rd_ctr_q == CTR_MAX && !frame_done) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // A new frame always restarts readout; arriving before the last bin was issued is an overrun.
  always_comb begin
    rd_issue  = (state_q == RD_READ);
    rd_ctr_d  = rd_ctr_q;
    rd_bank_d = rd_bank_q;
    overrun_d = overrun_q;
    if (frame_done) begin
      rd_ctr_d  = '0;
      rd_bank_d = ~wr_bank_q;
      if (rd_issue && rd_ctr_q != CTR_MAX) overrun_d = 1'b1;
    end else if (rd_issue) begin
      rd_ctr_d = rd_ctr_q + N_LOG2'(1);
    end
  end

  fft_bitrev_ram #(
    .AW (N_LOG2 + 1),
    .W  (2 * DW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (valid_i),
    .waddr_i ({wr_bank_q, wr_rev}),
    .wdata_i ({x_re_i, x_im_i}),
    .re_i    (rd_issue),
    .raddr_i ({rd_bank_q, rd_ctr_q}),
    .rdata_o (rdata)
  );

  assign valid_o   = valid_q;
  assign ctr_o     = ctr_q;
  assign last_o    = last_q;
  assign z_re_o    = rdata[2*DW-1:DW];
  assign z_im_o    = rdata[DW-1:0];
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Directed bench for the bit-reverse reorder buffer at N = 8.
module tb_fft_bitrev_buf;

  localparam int DW = 8;
  localparam int NL = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [DW-1:0] x_re_i, x_im_i;
  logic          valid_o;
  logic [NL-1:0] ctr_o;
  logic          last_o;
  logic [DW-1:0] z_re_o, z_im_o;
  logic          overrun_o;

  fft_bitrev_buf #(.DW(DW), .N_LOG2(NL)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .x_re_i    (x_re_i),
    .x_im_i    (x_im_i),
    .valid_o   (valid_o),
    .ctr_o     (ctr_o),
    .last_o    (last_o),
    .z_re_o    (z_re_o),
    .z_im_o    (z_im_o),
    .overrun_o (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int q_re[$], q_im[$], q_ctr[$], q_last[$], q_cyc[$];
  int n_chk = 0, n_pass = 0;
  int last_acc = 0;
  int ord[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always @(negedge clk_i) begin
    if (valid_o) begin
      q_re.push_back(int'(z_re_o));
      q_im.push_back(int'(z_im_o));
      q_ctr.push_back(int'(ctr_o));
      q_last.push_back(int'(last_o));
      q_cyc.push_back(cyc);
      $display("out cyc=%0d ctr=%0d last=%0b re=%0d im=%0d", cyc, ctr_o, last_o, z_re_o, z_im_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clear_q();
    q_re.delete(); q_im.delete(); q_ctr.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      valid_i = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input bit gap, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk_i);
      valid_i  = 1'b1;
      x_re_i   = 8'(base + i);
      x_im_i   = 8'(0) - 8'(base + i);
      last_acc = cyc + 1;
      if (gap) begin
        @(negedge clk_i);
        valid_i = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input int idx0, input int base, input int start);
    logic [7:0] er, ei;
    for (int k = 0; k < 8; k++) begin
      if (idx0 + k < q_re.size()) begin
        er = 8'(base + ord[k]);
        ei = 8'(0) - er;
        chk("z_re", 32'(q_re[idx0+k]), 32'(er));
        chk("z_im", 32'(q_im[idx0+k]), 32'(ei));
        chk("ctr", 32'(q_ctr[idx0+k]), 32'(k));
        chk("last", 32'(q_last[idx0+k]), (k == 7) ? 32'd1 : 32'd0);
        chk("timing", 32'(q_cyc[idx0+k]), 32'(start + k));
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_i   = 1'b1;
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_ctr", 32'(ctr_o), 32'd0);
    chk("rst_re", 32'(z_re_o), 32'd0);
    chk("rst_im", 32'(z_im_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  int l1;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; x_re_i = '0; x_im_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("init_valid", 32'(valid_o), 32'd0);
    chk("init_ctr", 32'(ctr_o), 32'd0);
    chk("init_re", 32'(z_re_o), 32'd0);
    chk("init_overrun", 32'(overrun_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single frame, continuous input
    send_frame(0, 1'b0, 8);
    idle(12);
    chk("s1_count", 32'(q_re.size()), 32'd8);
    check_frame(0, 0, last_acc + 2);
    clear_q();

    // Three back-to-back frames
    send_frame(16, 1'b0, 8);
    l1 = last_acc;
    send_frame(32, 1'b0, 8);
    send_frame(48, 1'b0, 8);
    idle(12);
    chk("s2_count", 32'(q_re.size()), 32'd24);
    check_frame(0, 16, l1 + 2);
    check_frame(8, 32, l1 + 10);
    check_frame(16, 48, l1 + 18);
    chk("s2_overrun", 32'(overrun_o), 32'd0);
    clear_q();

    // Gapped input
    send_frame(0, 1'b1, 8);
    idle(12);
    chk("s3_count", 32'(q_re.size()), 32'd8);
    check_frame(0, 0, last_acc + 2);
    clear_q();

    // Reset in the middle of writing a frame
    send_frame(100, 1'b0, 5);
    reset_dut();
    clear_q();
    send_frame(64, 1'b0, 8);
    idle(12);
    chk("s4_count", 32'(q_re.size()), 32'd8);
    check_frame(0, 64, last_acc + 2);
    clear_q();

    // Reset on the 4th output cycle
    send_frame(80, 1'b0, 8);
    idle(1);
    while (cyc < last_acc + 5) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("s5_async_valid", 32'(valid_o), 32'd0);
    chk("s5_async_re", 32'(z_re_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(15);
    chk("s5_count", 32'(q_re.size()), 32'd4);
    clear_q();

    // Forced frame_done while reading bin 3
    send_frame(0, 1'b0, 8);
    idle(1);
    l1 = last_acc;
    while (cyc < l1 + 4) @(negedge clk_i);
    chk("s6_pre_ctr", 32'(ctr_o), 32'd2);
    #2;
    force dut.frame_done = 1'b1;
    @(negedge clk_i);
    #2;
    release dut.frame_done;
    chk("s6_overrun", 32'(overrun_o), 32'd1);
    chk("s6_ctr3", 32'(ctr_o), 32'd3);
    idle(14);
    chk("s6_count", 32'(q_re.size()), 32'd12);
    for (int k = 0; k < 4; k++) begin
      if (k < q_ctr.size()) chk("s6_head_ctr", 32'(q_ctr[k]), 32'(k));
    end
    check_frame(4, 0, l1 + 6);
    chk("s6_sticky", 32'(overrun_o), 32'd1);
    reset_dut();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_buf.md
# fft_bitrev_buf

Output reorder buffer for the R2²SDF FFT pipeline. The pipeline's butterfly stages emit each frame's bins in bit-reversed order, one complex sample per valid cycle. This block captures each frame into one half of a ping-pong RAM at bit-reversed addresses and streams the previously captured frame out in natural bin order, with a bin index and frame-end marker for the downstream magnitude and host-transfer logic.

## Interface

Parameters:
- `DW`, default 24: width of each real and imaginary sample, two's complement.
- `N_LOG2`, default 10: log2 of FFT length; N = 2^N_LOG2.

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: single clock; all logic is in this domain.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `valid_i`, in, 1: input sample present this cycle. May be asserted every cycle; gaps are allowed.
- `x_re_i`, in, DW: real part of input sample, bit-reversed order.
- `x_im_i`, in, DW: imaginary part of input sample.
- `valid_o`, out, 1: output sample present.
- `ctr_o`, out, N_LOG2: natural-order bin index of the current output.
- `last_o`, out, 1: high with bin N-1.
- `z_re_o`, out, DW: real part of output sample.
- `z_im_o`, out, DW: imaginary part of output sample.
- `overrun_o`, out, 1: sticky error flag, cleared only by reset.

## Operation

Write side:
- `wr_ctr` (N_LOG2 bits) increments on every cycle with `valid_i`.
- The sample is written to bank `wr_bank` at address bitrev(`wr_ctr`).
- When a sample is accepted with `wr_ctr` = N-1:
  - `wr_ctr` wraps to 0.
  - `wr_bank` toggles.
  - A one-cycle `frame_done` pulse is raised.
- Input samples are never dropped and there is no backpressure.

Read FSM, two states, IDLE and READ:
- IDLE → READ on `frame_done`. At that point `rd_bank` ← the bank just filled and `rd_ctr` ← 0.
- In READ, issue a RAM read at (`rd_bank`, `rd_ctr`) every cycle and increment `rd_ctr`.
- After issuing address N-1:
  - If `frame_done` is high in the same cycle, restart READ on the new bank with `rd_ctr` = 0. Back-to-back frames therefore produce contiguous output.
  - Otherwise return to IDLE.
- `frame_done` while READ is mid-frame (`rd_ctr` ≠ N-1):
  - Set `overrun_o`.
  - Abandon the current readout and restart READ on the new bank at 0.
  - This cannot occur at ≤1 sample/cycle. It is a defensive check only.

Output register:
- `valid_o`, `ctr_o` and `last_o` are the read-issue signals delayed to align with the registered RAM data.
- `z_re_o` and `z_im_o` hold their last value while `valid_o` is low.

Reset values (all registers):
- `wr_ctr` = 0, `rd_ctr` = 0.
- `wr_bank` = 0.
- FSM in IDLE.
- `valid_o` = 0, `last_o` = 0, `ctr_o` = 0, `z_re_o` = 0, `z_im_o` = 0, `overrun_o` = 0.
- RAM contents are not reset.

Reset mid-operation discards both the partially written frame and any frame being read out. The first full frame after reset is output normally.

## Timing

Latency:
- Edge k accepts input sample N-1.
- Edge k+1: FSM enters READ and the address for bin 0 is registered.
- Edge k+2: RAM data is registered; `valid_o` is high with `ctr_o` = 0.
- Output sustains N consecutive valid cycles; `last_o` is high on the Nth.

Bank access and hazards:
- Read and write always target opposite banks, so there is no address hazard.
- The write of the next frame may begin on edge k+1.

Gaps:
- Input gaps delay `frame_done` only.
- Output is always gap-free within a frame.

## Structure

- `fft_pkg`: holds the `bitrev` function (width-parameterised) and the default `DW` / `N_LOG2` constants shared with the pipeline stages.
- One sub-module, `fft_bitrev_ram`: simple dual-port RAM with 2N words × 2·DW bits. The bank bit is the address MSB. It has a synchronous write port and a registered read port, and is inferred as block RAM.
- The top level holds the counters, the FSM and the output alignment.

## Test plan

All scenarios use N_LOG2 = 3.

1. **Natural-order recovery.** Feed one frame, continuous `valid_i`, `x_re_i` = 0..7, `x_im_i` = −`x_re_i`.
   - Required: `z_re_o` = 0,4,2,6,1,5,3,7, with matching imaginary parts.
   - `ctr_o` = 0..7; `last_o` high only on the 8th output.
   - First `valid_o` appears 2 cycles after the last input edge.
2. **Back-to-back frames.** Feed 3 consecutive frames.
   - Required: 24 contiguous `valid_o` cycles with correct per-frame data and no gap between frames.
   - `overrun_o` = 0 throughout.
3. **Gapped input.** Hold `valid_i` low every other cycle.
   - Required: output data is identical to scenario 1.
   - Output is still 8 contiguous cycles, starting 2 cycles after the 8th accepted sample.
4. **Reset mid-write.** Feed 5 samples, assert `rst_i` for 1 cycle, then feed a full frame.
   - Required: outputs are all 0 and `valid_o` is 0 during reset.
   - Exactly one output frame follows, containing only the post-reset data.
5. **Reset mid-read.** Assert `rst_i` on the 4th output cycle.
   - Required: `valid_o` drops asynchronously.
   - No further output until a new frame completes.
6. **Overrun check.** Force `frame_done` via a bind/force while READ is at `rd_ctr` = 3.
   - Required: `overrun_o` goes to 1 and stays 1.
   - Readout restarts at `ctr_o` = 0.
